// File: rtl/id_stage_pkg.sv
// Shared decode constants and the control bundle handed from ID into the ID/EX register.
package id_stage_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic pcsrc;
    logic alusrc;
    logic memtoreg;
    logic we;
    logic reg_en;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_stage_reg_file.sv
// Architectural register file: two combinational read ports with write-through
// bypass, one write port, synchronous active-low clear, x0 hardwired to zero.
module id_stage_reg_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   i_rs1_addr,
  input  logic [AW-1:0]   i_rs2_addr,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [XLEN-1:0] i_wr_data,
  input  logic            i_wr_en,
  output logic [XLEN-1:0] o_rd_data_1,
  output logic [XLEN-1:0] o_rd_data_2
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wr_live;

  assign w_wr_live = i_wr_en && (i_wr_addr != '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_live) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  // A writeback landing this edge is visible to the instruction being decoded now.
  always_comb begin
    o_rd_data_1 = r_regs[i_rs1_addr];
    if (i_rs1_addr == '0) begin
      o_rd_data_1 = '0;
    end else if (w_wr_live && (i_wr_addr == i_rs1_addr)) begin
      o_rd_data_1 = i_wr_data;
    end
  end

  always_comb begin
    o_rd_data_2 = r_regs[i_rs2_addr];
    if (i_rs2_addr == '0) begin
      o_rd_data_2 = '0;
    end else if (w_wr_live && (i_wr_addr == i_rs2_addr)) begin
      o_rd_data_2 = i_wr_data;
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV32I-subset decode stage: register read, control decode, immediate generation
// and load-use hazard detection feeding the ID/EX pipeline register.
module id_stage #(
  parameter int XLEN  = id_stage_pkg::XLEN,
  parameter int NREGS = id_stage_pkg::NREGS
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     instr_in,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            wb_en,
  input  logic [4:0]      ex_rd,
  input  logic            ex_memtoreg,
  output logic [XLEN-1:0] data_out_1,
  output logic [XLEN-1:0] data_out_2,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] imm_out,
  output logic            pcsrc_out,
  output logic            alusrc_out,
  output logic            memtoreg_out,
  output logic            we_out,
  output logic            reg_en_out,
  output logic            stall_out
);

  import id_stage_pkg::*;

  logic [6:0]        w_opcode;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic [REG_AW-1:0] w_rd_field;
  logic [REG_AW-1:0] w_rd_dec;
  logic [XLEN-1:0]   w_imm_i;
  logic [XLEN-1:0]   w_imm_s;
  logic [XLEN-1:0]   w_imm_b;
  logic [XLEN-1:0]   w_imm;
  ctrl_t             w_ctrl_dec;
  ctrl_t             w_ctrl_out;
  logic              w_uses_rs1;
  logic              w_uses_rs2;
  logic              w_stall;
  logic              w_unused_funct3;

  assign w_opcode   = instr_in[6:0];
  assign w_rd_field = instr_in[11:7];
  assign w_rs1      = instr_in[19:15];
  assign w_rs2      = instr_in[24:20];

  // funct3 only selects the ALU/memory operation further down the pipe.
  assign w_unused_funct3 = &{1'b0, instr_in[14:12]};

  assign w_imm_i = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
  assign w_imm_s = {{(XLEN-12){instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign w_imm_b = {{(XLEN-13){instr_in[31]}}, instr_in[31], instr_in[7],
                    instr_in[30:25], instr_in[11:8], 1'b0};

  id_stage_reg_file #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (REG_AW)
  ) u_reg_file (
    .clock       (clock),
    .reset       (reset),
    .i_rs1_addr  (w_rs1),
    .i_rs2_addr  (w_rs2),
    .i_wr_addr   (wb_rd),
    .i_wr_data   (wb_data),
    .i_wr_en     (wb_en),
    .o_rd_data_1 (data_out_1),
    .o_rd_data_2 (data_out_2)
  );

  always_comb begin
    w_ctrl_dec = CTRL_NOP;
    w_rd_dec   = '0;
    w_imm      = '0;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    unique case (w_opcode)
      OP_R: begin
        w_ctrl_dec.reg_en = 1'b1;
        w_rd_dec          = w_rd_field;
        w_uses_rs1        = 1'b1;
        w_uses_rs2        = 1'b1;
      end
      OP_IMM: begin
        w_ctrl_dec.reg_en = 1'b1;
        w_ctrl_dec.alusrc = 1'b1;
        w_rd_dec          = w_rd_field;
        w_imm             = w_imm_i;
        w_uses_rs1        = 1'b1;
      end
      OP_LOAD: begin
        w_ctrl_dec.reg_en   = 1'b1;
        w_ctrl_dec.alusrc   = 1'b1;
        w_ctrl_dec.memtoreg = 1'b1;
        w_rd_dec            = w_rd_field;
        w_imm               = w_imm_i;
        w_uses_rs1          = 1'b1;
      end
      OP_STORE: begin
        w_ctrl_dec.we     = 1'b1;
        w_ctrl_dec.alusrc = 1'b1;
        w_imm             = w_imm_s;
        w_uses_rs1        = 1'b1;
        w_uses_rs2        = 1'b1;
      end
      OP_BRANCH: begin
        w_ctrl_dec.pcsrc = 1'b1;
        w_imm            = w_imm_b;
        w_uses_rs1       = 1'b1;
        w_uses_rs2       = 1'b1;
      end
      default: begin
        w_ctrl_dec = CTRL_NOP;
      end
    endcase
  end

  // Only a load sitting in EX can't be forwarded in time; x0 never creates a dependency.
  assign w_stall = ex_memtoreg && (ex_rd != '0) &&
                   ((w_uses_rs1 && (ex_rd == w_rs1)) ||
                    (w_uses_rs2 && (ex_rd == w_rs2)));

  always_comb begin
    w_ctrl_out = CTRL_NOP;
    rd_out     = '0;
    imm_out    = '0;
    stall_out  = 1'b0;
    if (reset) begin
      stall_out = w_stall;
      imm_out   = w_imm;
      if (!w_stall) begin
        w_ctrl_out = w_ctrl_dec;
        rd_out     = w_rd_dec;
      end
    end
  end

  assign pcsrc_out    = w_ctrl_out.pcsrc;
  assign alusrc_out   = w_ctrl_out.alusrc;
  assign memtoreg_out = w_ctrl_out.memtoreg;
  assign we_out       = w_ctrl_out.we;
  assign reg_en_out   = w_ctrl_out.reg_en;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: driver pushes reference-model expectations,
// a negedge monitor pops and compares each presented decode.
module tb_id_stage;

  localparam int EW = 107;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr_in;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_en;
  logic [4:0]  ex_rd;
  logic        ex_memtoreg;
  logic [31:0] data_out_1;
  logic [31:0] data_out_2;
  logic [4:0]  rd_out;
  logic [31:0] imm_out;
  logic        pcsrc_out;
  logic        alusrc_out;
  logic        memtoreg_out;
  logic        we_out;
  logic        reg_en_out;
  logic        stall_out;

  logic [EW-1:0] exp_q[$];
  logic          care_q[$];
  logic [31:0]   model_rf[32];
  int            total = 0;
  int            bad   = 0;

  always #5 clock = ~clock;

  id_stage dut (
    .clock        (clock),
    .reset        (reset),
    .instr_in     (instr_in),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_en        (wb_en),
    .ex_rd        (ex_rd),
    .ex_memtoreg  (ex_memtoreg),
    .data_out_1   (data_out_1),
    .data_out_2   (data_out_2),
    .rd_out       (rd_out),
    .imm_out      (imm_out),
    .pcsrc_out    (pcsrc_out),
    .alusrc_out   (alusrc_out),
    .memtoreg_out (memtoreg_out),
    .we_out       (we_out),
    .reg_en_out   (reg_en_out),
    .stall_out    (stall_out)
  );

  function automatic logic [31:0] model_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_en && (wb_rd == r)) return wb_data;
    return model_rf[r];
  endfunction

  // Reference decode built from the instruction-set rules with integer offsets.
  task automatic model_push();
    logic [4:0] rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic pc, as, mt, we, re, u1, u2, st, care;
    int off;
    rs1 = instr_in[19:15];
    rs2 = instr_in[24:20];
    d1 = model_read(rs1);
    d2 = model_read(rs2);
    {pc, as, mt, we, re, u1, u2} = '0;
    rd = 5'd0;
    off = 0;
    case (instr_in[6:0])
      7'h33: begin re = 1; rd = instr_in[11:7]; u1 = 1; u2 = 1; end
      7'h13: begin re = 1; as = 1; rd = instr_in[11:7]; u1 = 1;
                   off = $signed(instr_in[31:20]); end
      7'h03: begin re = 1; as = 1; mt = 1; rd = instr_in[11:7]; u1 = 1;
                   off = $signed(instr_in[31:20]); end
      7'h23: begin we = 1; as = 1; u1 = 1; u2 = 1;
                   off = $signed({instr_in[31:25], instr_in[11:7]}); end
      7'h63: begin pc = 1; u1 = 1; u2 = 1;
                   off = $signed({instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0}); end
      default: ;
    endcase
    imm = 32'(off);
    st = ex_memtoreg && (ex_rd != 0) && ((u1 && ex_rd == rs1) || (u2 && ex_rd == rs2));
    care = 1'b1;
    if (!reset) begin
      {pc, as, mt, we, re, st} = '0;
      rd = 5'd0;
      imm = 32'd0;
    end else if (st) begin
      {pc, as, mt, we, re} = '0;
      rd = 5'd0;
      care = 1'b0;
    end
    exp_q.push_back({d1, d2, rd, imm, pc, as, mt, we, re, st});
    care_q.push_back(care);
  endtask

  task automatic drive(input logic rst, input logic [31:0] ins, input logic wen,
                       input logic [4:0] wrd, input logic [31:0] wdat,
                       input logic [4:0] erd, input logic emt, input bit check);
    @(posedge clock);
    if (!reset) begin
      for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    end else if (wb_en && wb_rd != 5'd0) begin
      model_rf[wb_rd] = wb_data;
    end
    #1;
    reset = rst; instr_in = ins; wb_en = wen; wb_rd = wrd; wb_data = wdat;
    ex_rd = erd; ex_memtoreg = emt;
    if (check) model_push();
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (instr %h)", name, act, exp, instr_in);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      logic c;
      e = exp_q.pop_front();
      c = care_q.pop_front();
      if (c) begin
        cmp("data_out_1", data_out_1, e[106:75]);
        cmp("data_out_2", data_out_2, e[74:43]);
        cmp("imm_out", imm_out, e[37:6]);
      end
      cmp("rd_out", {27'd0, rd_out}, {27'd0, e[42:38]});
      cmp("ctrl", {27'd0, pcsrc_out, alusrc_out, memtoreg_out, we_out, reg_en_out},
          {27'd0, e[5:1]});
      cmp("stall_out", {31'd0, stall_out}, {31'd0, e[0]});
    end
  end

  initial begin
    logic [31:0] ins;
    logic [6:0] ops [6];
    logic [4:0] erd;
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03;
    ops[3] = 7'h23; ops[4] = 7'h63; ops[5] = 7'h37;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    reset = 0; instr_in = 32'h33; wb_en = 0; wb_rd = 0; wb_data = 0;
    ex_rd = 0; ex_memtoreg = 0;

    // Reset for two edges; the second reset cycle also presents a load-use pair.
    drive(0, 32'h00000033, 0, 0, 0, 0, 0, 0);
    drive(0, 32'h00318133, 0, 0, 0, 5'd3, 1, 1);
    drive(1, 32'h00000033, 0, 0, 0, 0, 0, 1);
    // Writeback then read, same-cycle bypass, x0 writes.
    drive(1, 32'h00000033, 1, 5'd5, 32'hDEADBEEF, 0, 0, 1);
    drive(1, 32'h00028093, 0, 0, 0, 0, 0, 1);
    drive(1, 32'h00630033, 1, 5'd6, 32'h12345678, 0, 0, 1);
    drive(1, 32'h00000033, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 1);
    drive(1, 32'h00000093, 0, 0, 0, 0, 0, 1);
    // Immediate formats.
    drive(1, 32'hFFF00093, 0, 0, 0, 0, 0, 1);
    drive(1, 32'hFE000EE3, 0, 0, 0, 0, 0, 1);
    drive(1, 32'hFE002C23, 0, 0, 0, 0, 0, 1);
    // Load-use hazards.
    drive(1, 32'h00318133, 0, 0, 0, 5'd3, 1, 1);
    drive(1, 32'h00318133, 0, 0, 0, 5'd0, 1, 1);
    drive(1, 32'h00318133, 0, 0, 0, 5'd3, 0, 1);
    drive(1, 32'h00520393, 0, 0, 0, 5'd4, 1, 1);
    drive(1, 32'h00520393, 0, 0, 0, 5'd5, 1, 1);
    drive(1, 32'h00630033, 1, 5'd6, 32'hCAFEF00D, 5'd6, 1, 1);

    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 5)];
      case ($urandom_range(0, 3))
        0: erd = ins[19:15];
        1: erd = ins[24:20];
        2: erd = 5'd0;
        default: erd = 5'($urandom);
      endcase
      drive(($urandom_range(0, 49) != 0), ins, 1'($urandom),
            ($urandom_range(0, 2) == 0) ? ins[19:15] : 5'($urandom),
            $urandom, erd, 1'($urandom), 1);
    end

    repeat (3) @(posedge clock);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
